// File: rtl/dram_cache_pkg.sv
// dram_cache_pkg: shared request-entry layout and default sizing for the
//     index-extraction to tag-lookup request path.
package dram_cache_pkg;
    localparam int REQ_WIDTH      = 128;
    localparam int REQ_FIFO_DEPTH = 16;

    typedef struct packed {
        logic        is_write;
        logic [31:0] id;
        logic [31:0] addr;
        logic [3:0]  slave;
        logic [58:0] rsvd;
    } req_entry_t;
endpackage

// File: rtl/req_fifo_if.sv
// req_fifo_if: push/pop handshake bundle of req_fifo; ovf_o exists only when
//     REQ_FIFO_OVF_CHECK_EN is defined.
interface req_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
);
    logic                       wr_en_i;
    logic [WIDTH-1:0]           wr_data_i;
    logic                       afull_o;
    logic                       full_o;
    logic                       empty_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       rd_valid_o;
    logic [WIDTH-1:0]           rd_data_o;
    logic                       rd_ready_i;
`ifdef REQ_FIFO_OVF_CHECK_EN
    logic                       ovf_o;
`endif

    modport master (
        output wr_en_i, wr_data_i, rd_ready_i,
        input  afull_o, full_o, empty_o, count_o, rd_valid_o, rd_data_o
`ifdef REQ_FIFO_OVF_CHECK_EN
        , input ovf_o
`endif
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_ready_i,
        output afull_o, full_o, empty_o, count_o, rd_valid_o, rd_data_o
`ifdef REQ_FIFO_OVF_CHECK_EN
        , output ovf_o
`endif
    );
endinterface

// File: rtl/req_fifo_mem.sv
// req_fifo_mem: DEPTH x WIDTH storage, synchronous write, asynchronous read.
module req_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/req_fifo.sv
// req_fifo: show-ahead request FIFO with almost-full back-pressure flag.
//     Define REQ_FIFO_OVF_CHECK_EN for the sticky ovf_o flag and drop assertion.
module req_fifo
    import dram_cache_pkg::*;
#(
    parameter int DEPTH        = REQ_FIFO_DEPTH,
    parameter int WIDTH        = REQ_WIDTH,
    parameter int AFULL_MARGIN = 2
) (
    input logic      clk,
    input logic      rst,
    req_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(DEPTH - AFULL_MARGIN);

    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] w_count;
    logic        w_full, w_empty, w_pop, w_push;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = r_wr_ptr == r_rd_ptr;
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = !w_empty && bus.rd_ready_i;
    // A pop frees the slot this same edge, so a push at full is still taken.
    assign w_push  = bus.wr_en_i && (!w_full || w_pop);

    always_ff @(posedge clk)
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(w_push);
            r_rd_ptr <= r_rd_ptr + (AW+1)'(w_pop);
        end

    req_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk     (clk),
        .i_we    (w_push && !rst),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (bus.wr_data_i),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (bus.rd_data_o)
    );

    assign bus.count_o    = w_count;
    assign bus.empty_o    = w_empty;
    assign bus.full_o     = w_full;
    assign bus.afull_o    = w_count >= AFULL_LVL;
    assign bus.rd_valid_o = !w_empty;

`ifdef REQ_FIFO_OVF_CHECK_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = bus.wr_en_i && w_full && !w_pop;

    always_ff @(posedge clk)
        if (rst) r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;

    always_ff @(posedge clk)
        if (!rst) assert (!w_drop) else $warning("req_fifo: push dropped while full");

    assign bus.ovf_o = r_ovf;
`endif
endmodule

// File: tb/tb_req_fifo.sv
// tb_req_fifo: directed and random checks of req_fifo against a queue model;
//     ovf_o is checked when REQ_FIFO_OVF_CHECK_EN is defined.
module tb_req_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 128;
    localparam int MARGIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [WIDTH-1:0] q[$];
    logic ovf_m = 1'b0;

    always #5 clk = ~clk;

    req_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    req_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count", WIDTH'(bus.count_o), WIDTH'(q.size()));
        chk("empty", WIDTH'(bus.empty_o), WIDTH'(q.size() == 0));
        chk("full", WIDTH'(bus.full_o), WIDTH'(q.size() == DEPTH));
        chk("afull", WIDTH'(bus.afull_o), WIDTH'(DEPTH - q.size() <= MARGIN));
        chk("rd_valid", WIDTH'(bus.rd_valid_o), WIDTH'(q.size() != 0));
        if (q.size() != 0) chk("rd_data", bus.rd_data_o, q[0]);
`ifdef REQ_FIFO_OVF_CHECK_EN
        chk("ovf", WIDTH'(bus.ovf_o), WIDTH'(ovf_m));
`endif
    endtask

    task automatic cycle(input logic we, input logic [WIDTH-1:0] d, input logic rdy);
        bit pop, push;
        bus.wr_en_i    = we;
        bus.wr_data_i  = d;
        bus.rd_ready_i = rdy;
        pop  = q.size() != 0 && rdy;
        push = we && (q.size() < DEPTH || pop);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        if (we && !push) ovf_m = 1'b1;
        bus.wr_en_i    = 1'b0;
        bus.rd_ready_i = 1'b0;
        check_state();
    endtask

    task automatic do_reset(input logic we);
        rst            = 1'b1;
        bus.wr_en_i    = we;
        bus.wr_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.rd_ready_i = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        ovf_m       = 1'b0;
        rst         = 1'b0;
        bus.wr_en_i = 1'b0;
        check_state();
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        bus.wr_en_i    = 1'b0;
        bus.wr_data_i  = '0;
        bus.rd_ready_i = 1'b0;
        @(posedge clk);
        do_reset(1'b0);

        // Fill with 1..16, no pops.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0);
            chk("fill_afull", WIDTH'(bus.afull_o), WIDTH'(i >= 14));
            chk("fill_full", WIDTH'(bus.full_o), WIDTH'(i == DEPTH));
        end
        chk("fill_count", WIDTH'(bus.count_o), WIDTH'(DEPTH));

        // Overflow: dropped push of 0xDEAD.
        cycle(1'b1, WIDTH'(32'hDEAD), 1'b0);
        chk("ovf_count", WIDTH'(bus.count_o), WIDTH'(DEPTH));

        // Push with pop at full: 0xAA must come out last.
        cycle(1'b1, WIDTH'(8'hAA), 1'b1);
        chk("pp_full_count", WIDTH'(bus.count_o), WIDTH'(DEPTH));

        // Drain: heads 2..16 then 0xAA.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_head", bus.rd_data_o, (i == DEPTH - 1) ? WIDTH'(8'hAA) : WIDTH'(i + 2));
            cycle(1'b0, '0, 1'b1);
        end
        chk("drain_empty", WIDTH'(bus.empty_o), WIDTH'(1));

        // Push with ready at empty: count 1 then 0.
        cycle(1'b1, WIDTH'(16'h5555), 1'b1);
        chk("pp_empty_cnt1", WIDTH'(bus.count_o), WIDTH'(1));
        chk("pp_empty_data", bus.rd_data_o, WIDTH'(16'h5555));
        cycle(1'b0, '0, 1'b1);
        chk("pp_empty_cnt0", WIDTH'(bus.count_o), WIDTH'(0));

        // Random traffic with a mid-stream reset that also carries a push.
        for (int i = 0; i < 40; i++) begin
            if (i == 20) do_reset(1'b1);
            else cycle(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
